mux_4x1_seq: RTL and testbench

MUX_4X1_SEQ -- requirements
Module: mux_4x1_seq

---
 rtl/mux_pkg.sv | 6 +
 rtl/mux_4x1.sv | 13 +
 rtl/mux_4x1_seq.sv | 92 +++++++++
 tb/tb_mux_4x1_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared scan-FSM states and channel sizing for the sequential 4:1 mux scanner.
package mux_pkg;
  localparam int N_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
endpackage

// File: rtl/mux_4x1.sv
// mux_4x1: combinational 4:1 bit select; only built when MUX_SEQ_ECHO_CHECK_EN is defined,
// since the scanner uses it solely to form the expected echo bit.
`ifdef MUX_SEQ_ECHO_CHECK_EN
module mux_4x1
  import mux_pkg::*;
(
  input  logic [N_CH-1:0]  array_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             out_o
);
  assign out_o = array_i[sel_i];
endmodule
`endif

// File: rtl/mux_4x1_seq.sv
// mux_4x1_seq: latches a 4-bit word and scans it bit by bit through a downstream 4:1 mux.
// Optional echo check of mux_out_i enabled by MUX_SEQ_ECHO_CHECK_EN.
module mux_4x1_seq
  import mux_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          MSB_FIRST  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [N_CH-1:0]  array_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             bit_valid_o,
  output logic             last_o,
  output logic             busy_o,
  input  logic             mux_out_i,
  output logic             err_o
);
  localparam logic [SEL_W-1:0] FIRST = MSB_FIRST ? SEL_W'(N_CH - 1) : '0;
  localparam logic [SEL_W-1:0] LAST = MSB_FIRST ? '0 : SEL_W'(N_CH - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  state_e state_q, state_d;
  logic [N_CH-1:0] array_q, array_d;
  logic [SEL_W-1:0] sel_q, sel_d, sel_step;
  logic [3:0] gap_q, gap_d;
  logic is_last;
  assign sel_step = MSB_FIRST ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
  assign is_last = sel_q == LAST;
  always_comb begin
    state_d = state_q;
    array_d = array_q;
    sel_d = sel_q;
    gap_d = gap_q;
    case (state_q)
      IDLE: if (valid_i) begin
        state_d = SHIFT;
        array_d = data_i;
        sel_d = FIRST;
      end
      SHIFT: if (is_last) state_d = IDLE;
      else if (GAP_CYCLES == 0) sel_d = sel_step;
      else begin
        state_d = GAP;
        gap_d = GAP_LOAD;
      end
      GAP: if (gap_q == 4'd0) begin
        state_d = SHIFT;
        sel_d = sel_step;
      end else gap_d = gap_q - 4'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      array_q <= '0;
      sel_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      array_q <= array_d;
      sel_q <= sel_d;
      gap_q <= gap_d;
    end
  end
  assign ready_o = state_q == IDLE;
  assign busy_o = !ready_o;
  assign bit_valid_o = state_q == SHIFT;
  assign last_o = bit_valid_o && is_last;
  assign array_o = array_q;
  assign sel_o = sel_q;
`ifdef MUX_SEQ_ECHO_CHECK_EN
  logic exp_bit, err_q;
  mux_4x1 u_mux (
    .array_i(array_q),
    .sel_i  (sel_q),
    .out_o  (exp_bit)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else err_q <= err_q | (bit_valid_o && (mux_out_i != exp_bit));
  end
  assign err_o = err_q;
`else
  logic unused_mux;
  assign unused_mux = mux_out_i;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mux_4x1_seq.sv
// tb_mux_4x1_seq: scoreboard bench for two scanner configurations (default, and GAP=2 MSB-first).
module tb_mux_4x1_seq;
  import mux_pkg::*;
`ifdef MUX_SEQ_ECHO_CHECK_EN
  localparam int ECHO = 1;
`else
  localparam int ECHO = 0;
`endif
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic v0 = 0, v1 = 0, force_lo = 0;
  logic [3:0] d0 = 0, d1 = 0, arr0, arr1;
  logic [1:0] sel0, sel1;
  logic rdy0, rdy1, bv0, bv1, last0, last1, busy0, busy1, err0, err1, mo0, mo1;
  assign mo0 = force_lo ? 1'b0 : arr0[sel0];
  assign mo1 = arr1[sel1];
  mux_4x1_seq dut0 (
    .clk_i(clk), .rst_i(rst), .data_i(d0), .valid_i(v0), .ready_o(rdy0), .array_o(arr0),
    .sel_o(sel0), .bit_valid_o(bv0), .last_o(last0), .busy_o(busy0), .mux_out_i(mo0), .err_o(err0)
  );
  mux_4x1_seq #(.GAP_CYCLES(2), .MSB_FIRST(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(d1), .valid_i(v1), .ready_o(rdy1), .array_o(arr1),
    .sel_o(sel1), .bit_valid_o(bv1), .last_o(last1), .busy_o(busy1), .mux_out_i(mo1), .err_o(err1)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int sel; int b; int last; int cyc;} exp_t;
  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask
  task automatic push_word(input int dut, input logic [3:0] d, input int start, input int gap, input bit msb);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.sel = msb ? 3 - k : k;
      e.b = int'(d[e.sel]);
      e.last = (k == 3) ? 1 : 0;
      e.cyc = start + k * (gap + 1);
      if (dut == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask
  exp_t e0, e1;
  always @(negedge clk) if (bv0 === 1'b1) begin
    if (q0.size() == 0) chk("dut0 unexpected bit_valid", 1, 0);
    else begin
      e0 = q0.pop_front();
      chk("dut0 sel", int'(sel0), e0.sel);
      chk("dut0 bit", int'(arr0[sel0]), e0.b);
      chk("dut0 last", int'(last0), e0.last);
      chk("dut0 cycle", cyc, e0.cyc);
    end
  end
  always @(negedge clk) if (bv1 === 1'b1) begin
    if (q1.size() == 0) chk("dut1 unexpected bit_valid", 1, 0);
    else begin
      e1 = q1.pop_front();
      chk("dut1 sel", int'(sel1), e1.sel);
      chk("dut1 bit", int'(mo1), e1.b);
      chk("dut1 last", int'(last1), e1.last);
      chk("dut1 cycle", cyc, e1.cyc);
    end
  end
  initial begin
    int a;
    #1 rst = 1;
    #2;
    chk("rst ready", int'(rdy0), 1);
    chk("rst busy", int'(busy0), 0);
    chk("rst array", int'(arr0), 0);
    chk("rst sel", int'(sel0), 0);
    chk("rst bit_valid", int'(bv0), 0);
    chk("rst last", int'(last0), 0);
    chk("rst err", int'(err0), 0);
    chk("rst dut1 ready", int'(rdy1), 1);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("A ready", int'(rdy0), 1);
    v0 = 1; d0 = 4'b1010; a = cyc + 1;
    push_word(0, d0, a, 0, 0);
    @(negedge clk) v0 = 0;
    repeat (3) @(negedge clk);
    chk("A busy at last", int'(rdy0), 0);
    @(negedge clk);
    chk("A ready after scan", int'(rdy0), 1);
    chk("A array hold", int'(arr0), 4'b1010);
    chk("A sel hold", int'(sel0), 3);
    @(negedge clk);
    v1 = 1; d1 = 4'b0110; a = cyc + 1;
    push_word(1, d1, a, 2, 1);
    @(negedge clk) v1 = 0;
    repeat (9) @(negedge clk);
    chk("B busy at cycle 9", int'(rdy1), 0);
    @(negedge clk);
    chk("B ready at cycle 10", int'(rdy1), 1);
    @(negedge clk);
    v0 = 1; d0 = 4'hF; a = cyc + 1;
    push_word(0, d0, a, 0, 0);
    @(negedge clk) d0 = 4'h0;
    chk("C busy ignores valid", int'(rdy0), 0);
    repeat (3) @(negedge clk);
    chk("C last", int'(last0), 1);
    @(negedge clk);
    chk("C idle gap cycle", int'(rdy0), 1);
    push_word(0, 4'h0, a + 5, 0, 0);
    @(negedge clk) v0 = 0;
    chk("C second accept busy", int'(busy0), 1);
    chk("C second word", int'(arr0), 0);
    repeat (4) @(negedge clk);
    chk("C idle after second", int'(rdy0), 1);
    force_lo = 1;
    v0 = 1; d0 = 4'b0100; a = cyc + 1;
    push_word(0, d0, a, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) v0 = 0;
      chk("D err before sel2", int'(err0), 0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("D err sticky", int'(err0), ECHO);
    end
    force_lo = 0;
    v0 = 1; d0 = 4'b1101; a = cyc + 1;
    e0.sel = 0; e0.b = 1; e0.last = 0; e0.cyc = a;
    q0.push_back(e0);
    @(negedge clk) v0 = 0;
    @(posedge clk) #1 rst = 1;
    #1;
    chk("E rst bit_valid", int'(bv0), 0);
    chk("E rst array", int'(arr0), 0);
    chk("E rst sel", int'(sel0), 0);
    chk("E rst last", int'(last0), 0);
    chk("E rst err", int'(err0), 0);
    chk("E rst ready", int'(rdy0), 1);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("E no pulse after reset", int'(bv0), 0);
    end
    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
